led_scan_controller: RTL and testbench
======================================

# led_scan_controller

Column-scan sequencer for the LED matrix. It sits directly upstream of the LED array driver and generates the column index `x`, the column enable `ena` and a tear-free, frame-stable copy of the Conway cell grid. The game-of-life core hands over each new generation through a valid/ready handshake. The generation is double-buffered and shown only from the next frame boundary. Between columns the controller inserts a blanking interval so the matrix does not ghost.

## Interface
Parameters:
- `N`, 8: grid and LED array size, 1..8.
- `DWELL_CYCLES`, 1000: cycles each column is lit; must be ≥1.
- `BLANK_CYCLES`, 16: cycles of `ena`=0 before each column is lit; 0 is legal.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  display on/off.
- `cells_in`  in  N*N  new generation; row r occupies bits [r*N+N-1 : r*N].
- `cells_valid`  in  1  `cells_in` is valid.
- `cells_ready`  out  1  the shadow buffer can accept a generation.
- `x`  out  $clog2(N)+1  current column index, 0..N-1, to the driver.
- `ena`  out  1  column enable to the driver.
- `cells`  out  N*N  display buffer to the driver.
- `frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Buffers:
  - `shadow` plus a `shadow_full` flag.
  - `cells` is the display buffer.
- Accept rule: a transfer occurs on an edge with `cells_valid` && `cells_ready`. That edge writes `shadow` and sets `shadow_full`.
- `cells_ready` = !`shadow_full`, registered. While `shadow_full` is set, the producer stalls and `cells_in` is ignored.
- Swap: `cells` <= `shadow` and `shadow_full` clears. A swap happens only at the frame-boundary edge or on any edge in IDLE, and only when `shadow_full` was already set before that edge.
- A transfer on the swap edge lands in `shadow` and is displayed in the following frame.
- FSM states: IDLE, BLANK, SHOW. A phase counter `cnt` restarts at 0 on every state entry.
  - IDLE: `x`=0, `ena`=0. When `enable`=1, go to BLANK, or to SHOW if BLANK_CYCLES=0.
  - BLANK: `ena`=0. When `cnt`=BLANK_CYCLES-1, go to SHOW.
  - SHOW: `ena`=1. When `cnt`=DWELL_CYCLES-1, the column ends:
    - if `x`=N-1: `x` <= 0, pulse `frame_done`, perform the swap if pending;
    - otherwise `x` <= `x`+1;
    - next state is BLANK, or SHOW if BLANK_CYCLES=0.
- `enable`=0 in BLANK or SHOW: the next edge goes to IDLE with `x` <= 0 and `ena` <= 0. An aborted frame produces no `frame_done`.
- Arithmetic:
  - `x` increments within $clog2(N)+1 bits and never exceeds N-1.
  - The MSB of `x` is always 0.
  - `cnt` is wide enough for max(DWELL_CYCLES, BLANK_CYCLES).

## Timing
- Reset values: `x`=0, `ena`=0, `cells`=0, `cells_ready`=1, `frame_done`=0, `shadow_full`=0, state IDLE. Reset mid-frame discards `shadow` and takes effect on the next edge.
- All outputs are registered; none has a combinational path from any input.
- Column period is BLANK_CYCLES+DWELL_CYCLES cycles. Frame period is N×(BLANK_CYCLES+DWELL_CYCLES).
- `ena` is high for exactly DWELL_CYCLES consecutive cycles per column.
- `x` changes only on the edge where `ena` falls; with BLANK_CYCLES=0, that is the edge where `ena` stays high. `x` is therefore stable while `ena`=1.
- `cells` changes only on the edge where `x` returns to 0, or in IDLE, so a frame never mixes two generations.
- `frame_done` is high in the cycle immediately after the last SHOW cycle of column N-1, i.e. the first cycle with `x`=0.
- Handshake latency:
  - `cells_ready` falls one cycle after a transfer.
  - It rises one cycle after the swap.
  - Minimum latency from handshake to display is one cycle in IDLE and up to one frame while scanning.
- First lit column after `enable` rises: `ena`=1 after 1+BLANK_CYCLES cycles.

## Test plan
- Reset, then N=8, DWELL=4, BLANK=2, `enable`=1 → after the first BLANK, `x` steps 0..7 and wraps to 0. `ena` is 0 for 2 cycles then 1 for 4 cycles per column. `frame_done` pulses once every 48 cycles.
- BLANK=0, DWELL=1 → `ena` is held at 1 and `x` increments every cycle; `frame_done` pulses every 8 cycles.
- In IDLE, send `cells_in`=64'h0000_0000_0000_0001 with `cells_valid`=1 → `cells` equals that value two edges later and `cells_ready` returns to 1.
- While scanning at `x`=3, transfer 64'hFF; hold `cells_valid` high with 64'hAA → `cells` stays old until `x` wraps to 0, then becomes 64'hFF. 64'hAA is accepted only after `cells_ready` rises again and is displayed on the next wrap.
- Deassert `enable` at `x`=5 in SHOW → next edge `ena`=0, `x`=0, no `frame_done`. Re-enabling restarts at column 0 with BLANK.
- Assert `rst` mid-SHOW with `shadow_full`=1 → next edge: all outputs at reset values, `cells_ready`=1, pending generation discarded.

Source files
------------

// File: rtl/led_scan_controller.sv
// Column-scan sequencer for the LED matrix: steps the column index, gates the
// column enable with a blanking gap, and holds a frame-stable copy of the grid.
// Latency: every output is registered; a new generation is shown one edge after
// it is stored in IDLE, or at the next frame wrap while scanning.
// Backpressure: cells_ready drops while a generation is waiting in the shadow
// buffer, and rises again on the edge that moves it to the display buffer.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   enable        display on/off; dropping it aborts the frame and returns to IDLE
//   cells_in      new generation, row r at bits [r*N+N-1 : r*N]
//   cells_valid   producer has a generation on cells_in
//   cells_ready   shadow buffer is empty and can take a generation
//   x             column index to the driver, 0..N-1
//   ena           column enable to the driver
//   cells         display buffer to the driver
//   frame_done    single-cycle pulse in the first cycle after a completed frame
module led_scan_controller #(
  parameter int N            = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N*N-1:0]     cells_in,
  input  logic               cells_valid,
  output logic               cells_ready,
  output logic [$clog2(N):0] x,
  output logic               ena,
  output logic [N*N-1:0]     cells,
  output logic               frame_done
);

  localparam int XW   = $clog2(N) + 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // With no blanking the scan goes straight from one lit column to the next.
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]   x_nxt;
  logic            ena_nxt;
  logic            frame_done_nxt;
  logic [N*N-1:0]  shadow, shadow_nxt;
  logic            shadow_full, shadow_full_nxt;
  logic [N*N-1:0]  cells_nxt;
  logic            cells_ready_nxt;
  logic            xfer;
  logic            swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      x           <= '0;
      ena         <= 1'b0;
      frame_done  <= 1'b0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      cells       <= '0;
      cells_ready <= 1'b1;
    end else begin
      cnt         <= cnt_nxt;
      x           <= x_nxt;
      ena         <= ena_nxt;
      frame_done  <= frame_done_nxt;
      shadow      <= shadow_nxt;
      shadow_full <= shadow_full_nxt;
      cells       <= cells_nxt;
      cells_ready <= cells_ready_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 1'b1;
    x_nxt          = x;
    ena_nxt        = ena;
    frame_done_nxt = 1'b0;
    swap           = 1'b0;

    case (state)
      IDLE: begin
        x_nxt   = '0;
        ena_nxt = 1'b0;
        cnt_nxt = '0;
        // Nothing is on display in IDLE, so a pending generation moves over at once.
        swap    = shadow_full;
        if (enable) begin
          state_nxt = NO_BLANK ? SHOW : BLANK;
          ena_nxt   = NO_BLANK;
        end
      end

      BLANK: begin
        if (!enable) begin
          state_nxt = IDLE;
          x_nxt     = '0;
          ena_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          ena_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end

      SHOW: begin
        if (!enable) begin
          state_nxt = IDLE;
          x_nxt     = '0;
          ena_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt == DWELL_LAST) begin
          state_nxt = NO_BLANK ? SHOW : BLANK;
          ena_nxt   = NO_BLANK;
          cnt_nxt   = '0;
          if (x == X_LAST) begin
            // Frame boundary: the only point mid-scan where the display may change.
            x_nxt          = '0;
            frame_done_nxt = 1'b1;
            swap           = shadow_full;
          end else begin
            x_nxt = x + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        x_nxt     = '0;
        ena_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // cells_ready mirrors !shadow_full, so a transfer and a swap never share an edge.
  always_comb begin
    xfer            = cells_valid && cells_ready;
    shadow_nxt      = xfer ? cells_in : shadow;
    cells_nxt       = swap ? shadow : cells;
    shadow_full_nxt = xfer || (shadow_full && !swap);
    cells_ready_nxt = !shadow_full_nxt;
  end

endmodule

// File: tb/tb_led_scan_controller.sv
module tb_led_scan_controller;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int P  = D + B;
  localparam int NP = N * P;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, cells_valid;
  logic [63:0] cells_in;
  logic        cells_ready, ena, frame_done;
  logic [3:0]  x;
  logic [63:0] cells;

  logic        enable_b, cells_valid_b;
  logic [63:0] cells_in_b;
  logic        cells_ready_b, ena_b, frame_done_b;
  logic [3:0]  x_b;
  logic [63:0] cells_b;

  int checks = 0;
  int errors = 0;

  led_scan_controller #(.N(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .cells_in(cells_in), .cells_valid(cells_valid),
    .cells_ready(cells_ready), .x(x), .ena(ena), .cells(cells), .frame_done(frame_done)
  );

  led_scan_controller #(.N(N), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .cells_in(cells_in_b), .cells_valid(cells_valid_b),
    .cells_ready(cells_ready_b), .x(x_b), .ena(ena_b), .cells(cells_b), .frame_done(frame_done_b)
  );

  // Reference model for dut_a: scanning position is just the number of cycles
  // since the scan started; column, phase and frame wrap follow by division.
  logic        m_scan = 1'b0;
  int          m_c = 0;
  logic        m_full = 1'b0;
  logic [63:0] m_shadow = '0, m_cells = '0;
  logic [3:0]  e_x;
  logic        e_ena, e_fd, e_rdy;
  logic [63:0] e_cells;

  task automatic tick();
    logic xfer, boundary, swap;
    @(posedge clk);
    if (rst) begin
      m_scan = 1'b0; m_c = 0; m_full = 1'b0; m_shadow = '0; m_cells = '0;
    end else begin
      xfer     = cells_valid && !m_full;
      boundary = m_scan && enable && (m_c % NP == NP - 1);
      swap     = m_full && (!m_scan || boundary);
      if (swap) begin m_cells = m_shadow; m_full = 1'b0; end
      if (xfer) begin m_shadow = cells_in; m_full = 1'b1; end
      if (!m_scan) begin
        if (enable) begin m_scan = 1'b1; m_c = 0; end
      end else if (!enable) begin
        m_scan = 1'b0;
      end else begin
        m_c++;
      end
    end
    e_x     = m_scan ? 4'((m_c / P) % N) : 4'd0;
    e_ena   = m_scan && ((m_c % P) >= B);
    e_fd    = m_scan && (m_c > 0) && (m_c % NP == 0);
    e_rdy   = !m_full;
    e_cells = m_cells;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({x, ena, frame_done, cells_ready} !== {4'd0, 1'b0, 1'b0, 1'b1} || cells !== 64'd0) begin
      errors++;
      $display("FAIL reset_a x=%0d ena=%0b fd=%0b rdy=%0b cells=%h, want 0/0/0/1/0", x, ena, frame_done, cells_ready, cells);
    end
    checks++;
    if ({x_b, ena_b, frame_done_b, cells_ready_b} !== {4'd0, 1'b0, 1'b0, 1'b1} || cells_b !== 64'd0) begin
      errors++;
      $display("FAIL reset_b x=%0d ena=%0b fd=%0b rdy=%0b cells=%h, want 0/0/0/1/0", x_b, ena_b, frame_done_b, cells_ready_b, cells_b);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
      errors++;
      $display("FAIL idle_after_reset x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
               x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
    end
  endtask

  task automatic test_no_blank();
    enable_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (x_b !== 4'(i % 8) || ena_b !== 1'b1 || frame_done_b !== ((i > 0) && (i % 8 == 0))) begin
        errors++;
        $display("FAIL no_blank cyc=%0d x=%0d ena=%0b fd=%0b, want x=%0d ena=1 fd=%0b",
                 i, x_b, ena_b, frame_done_b, i % 8, (i > 0) && (i % 8 == 0));
      end
    end
    enable_b = 1'b0;
    tick();
    checks++;
    if (ena_b !== 1'b0 || x_b !== 4'd0) begin
      errors++;
      $display("FAIL no_blank_stop ena=%0b x=%0d, want 0/0", ena_b, x_b);
    end
  endtask

  task automatic test_scan();
    int pulses;
    pulses = 0;
    enable = 1'b1;
    for (int i = 0; i < 2 * NP + 10; i++) begin
      tick();
      if (frame_done) pulses++;
      checks++;
      if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
        errors++;
        $display("FAIL scan cyc=%0d x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
                 i, x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL scan_frame_count got %0d pulses, want 2", pulses);
    end
  endtask

  task automatic test_idle_load();
    enable = 1'b0;
    tick();
    tick();
    cells_in    = 64'h0000_0000_0000_0001;
    cells_valid = 1'b1;
    tick();
    cells_valid = 1'b0;
    checks++;
    if (cells_ready !== 1'b0 || cells !== 64'd0) begin
      errors++;
      $display("FAIL idle_load_accept rdy=%0b cells=%h, want rdy=0 cells=0", cells_ready, cells);
    end
    tick();
    checks++;
    if (cells_ready !== 1'b1 || cells !== 64'h1) begin
      errors++;
      $display("FAIL idle_load_show rdy=%0b cells=%h, want rdy=1 cells=1", cells_ready, cells);
    end
    checks++;
    if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
      errors++;
      $display("FAIL idle_load_model x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
               x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
    end
  endtask

  task automatic test_scan_load();
    bit found;
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (x == 4'd3) && ena;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_load_wait_x3 timeout x=%0d ena=%0b", x, ena);
    end
    cells_in    = 64'hFF;
    cells_valid = 1'b1;
    tick();
    checks++;
    if (cells_ready !== 1'b0 || cells !== 64'h1) begin
      errors++;
      $display("FAIL scan_load_accept rdy=%0b cells=%h, want rdy=0 cells=1", cells_ready, cells);
    end
    cells_in = 64'hAA;
    found    = 1'b0;
    for (int i = 0; i < NP + 5 && !found; i++) begin
      tick();
      found = frame_done;
      checks++;
      if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
        errors++;
        $display("FAIL scan_load_hold x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
                 x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
      end
    end
    checks++;
    if (!found || cells !== 64'hFF || cells_ready !== 1'b1 || x !== 4'd0) begin
      errors++;
      $display("FAIL scan_load_wrap fd_seen=%0b cells=%h rdy=%0b x=%0d, want 1/ff/1/0", found, cells, cells_ready, x);
    end
    tick();
    cells_valid = 1'b0;
    checks++;
    if (cells_ready !== 1'b0 || cells !== 64'hFF) begin
      errors++;
      $display("FAIL scan_load_second_accept rdy=%0b cells=%h, want rdy=0 cells=ff", cells_ready, cells);
    end
    found = 1'b0;
    for (int i = 0; i < NP + 5 && !found; i++) begin
      tick();
      found = frame_done;
      checks++;
      if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
        errors++;
        $display("FAIL scan_load_hold2 x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
                 x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
      end
    end
    checks++;
    if (!found || cells !== 64'hAA || cells_ready !== 1'b1) begin
      errors++;
      $display("FAIL scan_load_wrap2 fd_seen=%0b cells=%h rdy=%0b, want 1/aa/1", found, cells, cells_ready);
    end
  endtask

  task automatic test_abort();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (x == 4'd5) && ena;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_wait_x5 timeout x=%0d ena=%0b", x, ena);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (x !== 4'd0 || ena !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort x=%0d ena=%0b fd=%0b, want 0/0/0", x, ena, frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
        errors++;
        $display("FAIL abort_idle x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
                 x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (x !== 4'd0 || ena !== (k == 2) || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_restart k=%0d x=%0d ena=%0b fd=%0b, want x=0 ena=%0b fd=0", k, x, ena, frame_done, k == 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = (x == 4'd2) && ena && cells_ready;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait timeout x=%0d ena=%0b rdy=%0b", x, ena, cells_ready);
    end
    cells_in    = {$urandom, $urandom} | 64'h1000;
    cells_valid = 1'b1;
    tick();
    cells_valid = 1'b0;
    checks++;
    if (cells_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pending rdy=%0b, want 0", cells_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({x, ena, frame_done, cells_ready} !== {4'd0, 1'b0, 1'b0, 1'b1} || cells !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid x=%0d ena=%0b fd=%0b rdy=%0b cells=%h, want 0/0/0/1/0", x, ena, frame_done, cells_ready, cells);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (cells !== 64'd0 || cells_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_discard cells=%h rdy=%0b, want 0/1", cells, cells_ready);
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      rst         = ($urandom_range(0, 999) < 2);
      cells_valid = $urandom_range(0, 1);
      cells_in    = {$urandom, $urandom};
      tick();
      checks++;
      if ({x, ena, frame_done, cells_ready} !== {e_x, e_ena, e_fd, e_rdy} || cells !== e_cells) begin
        errors++;
        $display("FAIL random cyc=%0d x=%0d/%0d ena=%0b/%0b fd=%0b/%0b rdy=%0b/%0b cells=%h/%h (got/want)",
                 i, x, e_x, ena, e_ena, frame_done, e_fd, cells_ready, e_rdy, cells, e_cells);
      end
    end
    rst         = 1'b0;
    cells_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    cells_valid   = 1'b0;
    cells_in      = '0;
    enable_b      = 1'b0;
    cells_valid_b = 1'b0;
    cells_in_b    = '0;
    #1;
    test_reset();
    test_no_blank();
    test_scan();
    test_idle_load();
    test_scan_load();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
